// File: rtl/if_prefetch_stage.sv
// Instruction fetch with split addr/data handshake, pending-PC tracking
// and a PC+instruction prefetch FIFO feeding the ID stage.
module if_prefetch_stage #(
    parameter logic [31:0] RESET_PC        = 32'hbfc00000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        id_allow_in,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        if_to_id_valid,
    output logic [31:0] if_to_id_pc,
    output logic [31:0] if_to_id_instruction,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] out_cnt_q, out_cnt_d;
    logic [OW-1:0] discard_q, discard_d;

    logic [31:0]   pend_pc_q [MAX_OUTSTANDING];
    logic [31:0]   pend_pc_d [MAX_OUTSTANDING];
    logic [PW-1:0] pend_wr_q, pend_wr_d;
    logic [PW-1:0] pend_rd_q, pend_rd_d;

    logic [31:0]   fifo_pc_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc_d [FIFO_DEPTH];
    logic [31:0]   fifo_ins_q [FIFO_DEPTH];
    logic [31:0]   fifo_ins_d [FIFO_DEPTH];
    logic [AW-1:0] fifo_wr_q, fifo_wr_d;
    logic [AW-1:0] fifo_rd_q, fifo_rd_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic [31:0]   credit_used;
    logic          data_vld;
    logic          issue;
    logic          push;
    logic          pop;

    function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
        return p + PW'(1);
    endfunction

    // Words still owed to discard already hold no FIFO credit.
    assign credit_used = 32'(fifo_cnt_q) + 32'(out_cnt_q) - 32'(discard_q);

    assign data_vld = inst_data_ok && (out_cnt_q != '0);

    assign inst_req = reset_n && !branch_taken
                   && (32'(out_cnt_q) < MAX_OUTSTANDING)
                   && (credit_used < FIFO_DEPTH);

    assign issue = inst_req && inst_addr_ok;
    assign push  = data_vld && (discard_q == '0);
    assign pop   = if_to_id_valid && id_allow_in;

    assign inst_addr            = fetch_pc_q;
    assign if_to_id_valid       = (fifo_cnt_q != '0);
    assign if_to_id_pc          = fifo_pc_q[fifo_rd_q];
    assign if_to_id_instruction = fifo_ins_q[fifo_rd_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_cnt_d  = out_cnt_q + OW'(issue) - OW'(data_vld);
        discard_d  = discard_q;
        pend_pc_d  = pend_pc_q;
        pend_wr_d  = pend_wr_q;
        pend_rd_d  = pend_rd_q;
        fifo_pc_d  = fifo_pc_q;
        fifo_ins_d = fifo_ins_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);

        if (issue) begin
            fetch_pc_d           = fetch_pc_q + 32'd4;
            pend_pc_d[pend_wr_q] = fetch_pc_q;
            pend_wr_d            = pend_inc(pend_wr_q);
        end

        if (data_vld) begin
            pend_rd_d = pend_inc(pend_rd_q);
            if (discard_q != '0) discard_d = discard_q - OW'(1);
        end

        if (push) begin
            fifo_pc_d[fifo_wr_q]  = pend_pc_q[pend_rd_q];
            fifo_ins_d[fifo_wr_q] = inst_rdata;
            fifo_wr_d             = fifo_wr_q + AW'(1);
        end

        if (pop) fifo_rd_d = fifo_rd_q + AW'(1);

        // Pending PCs stay queued so later returns still pair up in order.
        if (branch_taken) begin
            fetch_pc_d = branch_target;
            discard_d  = out_cnt_q - OW'(data_vld);
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            out_cnt_q  <= '0;
            discard_q  <= '0;
            pend_wr_q  <= '0;
            pend_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_cnt_q  <= out_cnt_d;
            discard_q  <= discard_d;
            pend_wr_q  <= pend_wr_d;
            pend_rd_q  <= pend_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        pend_pc_q  <= pend_pc_d;
        fifo_pc_q  <= fifo_pc_d;
        fifo_ins_q <= fifo_ins_d;
    end

    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (!(inst_data_ok && (out_cnt_q == '0)))
            else $warning("stray inst_data_ok with nothing outstanding, ignored");
        end
    end

endmodule
